// File: rtl/pixel_scan_pkg.sv
// Shared timing constants and colour type for the pixel scan reader.
// Fixed 640x480 raster timing; only the totals are overridable at the top.
package pixel_scan_pkg;

   localparam int unsigned H_ACTIVE     = 640;
   localparam int unsigned V_ACTIVE     = 480;
   localparam int unsigned H_SYNC_START = 656;
   localparam int unsigned H_SYNC_END   = 752;
   localparam int unsigned V_SYNC_START = 490;
   localparam int unsigned V_SYNC_END   = 492;
   localparam int unsigned H_TOTAL_DEF  = 800;
   localparam int unsigned V_TOTAL_DEF  = 525;
   localparam int unsigned SCALE_SHIFT  = 1;

   typedef logic [23:0] rgb_t;

   localparam rgb_t RGB_BLACK  = 24'h000000;
   localparam rgb_t RGB_WHITE  = 24'hFFFFFF;
   localparam rgb_t RGB_BORDER = 24'hFF0000;

endpackage

// File: rtl/scan_timing_gen.sv
// Raster h/v counters advancing on pixel ticks, with active-video and
// (unregistered) active-low sync decode of the current counter values.
module scan_timing_gen
   import pixel_scan_pkg::*;
#(
   parameter int unsigned H_TOTAL = H_TOTAL_DEF,
   parameter int unsigned V_TOTAL = V_TOTAL_DEF,
   parameter int unsigned HW      = 10,
   parameter int unsigned VW      = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_tick,
   output logic [HW-1:0] h,
   output logic [VW-1:0] v,
   output logic          active,
   output logic          hs_n,
   output logic          vs_n,
   output logic          first
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (pix_tick) begin
         if (h == HW'(H_TOTAL - 1)) begin
            h <= '0;
            if (v == VW'(V_TOTAL - 1))
               v <= '0;
            else
               v <= v + VW'(1);
         end else begin
            h <= h + HW'(1);
         end
      end
   end

   always_comb begin
      active = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
      hs_n   = !((h >= HW'(H_SYNC_START)) && (h < HW'(H_SYNC_END)));
      vs_n   = !((v >= VW'(V_SYNC_START)) && (v < VW'(V_SYNC_END)));
      first  = (h == '0) && (v == '0);
   end

endmodule

// File: rtl/pixel_scan_reader.sv
// Scans a 320x240 1-bpp bitmap out as 2x-scaled 640x480 video at clk/2.
// Optional red frame border when PIXEL_SCAN_BORDER_EN is defined.
module pixel_scan_reader
   import pixel_scan_pkg::*;
#(
   parameter int unsigned N       = 32,
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned V_TOTAL = 525
) (
   input  logic         clk,
   input  logic         reset,
   output logic [N-1:0] mem_addr,
   output logic         mem_rd_en,
   input  logic [N-1:0] mem_data,
   output logic         hsync,
   output logic         vsync,
   output logic [23:0]  rgb,
   output logic         frame_start
);

   localparam int unsigned HW   = $clog2(H_TOTAL);
   localparam int unsigned VW   = $clog2(V_TOTAL);
   localparam int unsigned HALF = N / 2;

   logic          pix_tick;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          active;
   logic          hs_n;
   logic          vs_n;
   logic          first;
   logic [HALF-1:0] row;
   logic [HALF-1:0] col;
   rgb_t          pix_rgb;
   logic          mem_data_unused;

   assign mem_data_unused = ^mem_data[N-1:1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pix_tick <= 1'b0;
      else
         pix_tick <= ~pix_tick;
   end

   scan_timing_gen #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL),
      .HW      (HW),
      .VW      (VW)
   ) u_timing (
      .clk      (clk),
      .reset    (reset),
      .pix_tick (pix_tick),
      .h        (h),
      .v        (v),
      .active   (active),
      .hs_n     (hs_n),
      .vs_n     (vs_n),
      .first    (first)
   );

   // Address tracks the counters; the memory registers it on the mid-tick
   // edge, so its data is ready at the following tick edge.
   assign row       = HALF'(v >> SCALE_SHIFT);
   assign col       = HALF'(h >> SCALE_SHIFT);
   assign mem_rd_en = active && !reset;
   assign mem_addr  = mem_rd_en ? {row, col} : '0;

`ifdef PIXEL_SCAN_BORDER_EN
   logic on_border;
   assign on_border = (h == '0) || (h == HW'(H_ACTIVE - 1)) ||
                      (v == '0) || (v == VW'(V_ACTIVE - 1));
`endif

   always_comb begin
      pix_rgb = RGB_BLACK;
      if (active) begin
         pix_rgb = mem_data[0] ? RGB_WHITE : RGB_BLACK;
`ifdef PIXEL_SCAN_BORDER_EN
         if (on_border)
            pix_rgb = RGB_BORDER;
`endif
      end
   end

   // frame_start is refreshed every clk so it drops on the mid-tick edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb         <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_tick && first;
         if (pix_tick) begin
            rgb   <= pix_rgb;
            hsync <= hs_n;
            vsync <= vs_n;
         end
      end
   end

endmodule

// File: tb/tb_pixel_scan_reader.sv
// Directed self-checking bench for pixel_scan_reader (default 800x525 timing).
// Border expectations follow PIXEL_SCAN_BORDER_EN when it is defined.
module tb_pixel_scan_reader;

   localparam int N = 32;

`ifdef PIXEL_SCAN_BORDER_EN
   localparam logic [23:0] EDGE_ONE  = 24'hFF0000;
   localparam logic [23:0] EDGE_ZERO = 24'hFF0000;
`else
   localparam logic [23:0] EDGE_ONE  = 24'hFFFFFF;
   localparam logic [23:0] EDGE_ZERO = 24'h000000;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  mem_addr;
   logic          mem_rd_en;
   logic [N-1:0]  mem_data;
   logic          hsync;
   logic          vsync;
   logic [23:0]   rgb;
   logic          frame_start;

   int unsigned   mode = 1;
   int            passed = 0;
   int            total = 0;

   always #5 clk = ~clk;

   // Registered-read memory: 0 -> bit0 set only at address 0, 1 -> all ones, else zeros.
   always @(posedge clk) begin
      case (mode)
         0:       mem_data <= {{(N-1){1'b0}}, (mem_addr == '0)};
         1:       mem_data <= '1;
         default: mem_data <= '0;
      endcase
   end

   pixel_scan_reader #(
      .N       (N),
      .H_TOTAL (800),
      .V_TOTAL (525)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_addr    (mem_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_data    (mem_data),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb),
      .frame_start (frame_start)
   );

   // Releases reset on a falling edge; output pixel k then appears at negedge 2+2k.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      mode = 1;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (rgb !== 24'h0) $display("FAIL rst_rgb: got %h expected %h", rgb, 24'h0); else passed++;
      total++; if (hsync !== 1'b1) $display("FAIL rst_hsync: got %b expected 1", hsync); else passed++;
      total++; if (vsync !== 1'b1) $display("FAIL rst_vsync: got %b expected 1", vsync); else passed++;
      total++; if (frame_start !== 1'b0) $display("FAIL rst_fs: got %b expected 0", frame_start); else passed++;
      total++; if (mem_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b expected 0", mem_rd_en); else passed++;
      total++; if (mem_addr !== '0) $display("FAIL rst_addr: got %h expected 0", mem_addr); else passed++;
      reset = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 1) begin
            total++; if (frame_start !== 1'b0) $display("FAIL fs_c1: got %b expected 0", frame_start); else passed++;
         end
         if (c == 2) begin
            total++; if (frame_start !== 1'b1) $display("FAIL fs_c2: got %b expected 1", frame_start); else passed++;
         end
         if (c == 3) begin
            total++; if (frame_start !== 1'b0) $display("FAIL fs_c3: got %b expected 0", frame_start); else passed++;
         end
      end
      // c=200 shows pixel (99,0) with counters at (100,0).
      total++; if (rgb !== 24'hFFFFFF) $display("FAIL mid_rgb: got %h expected %h", rgb, 24'hFFFFFF); else passed++;
      total++; if (mem_addr !== 32'd50) $display("FAIL mid_addr: got %h expected %h", mem_addr, 32'd50); else passed++;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      total++; if (rgb !== 24'h0) $display("FAIL async_rgb: got %h expected 0", rgb); else passed++;
      total++; if (mem_rd_en !== 1'b0) $display("FAIL async_rd_en: got %b expected 0", mem_rd_en); else passed++;
      total++; if (mem_addr !== '0) $display("FAIL async_addr: got %h expected 0", mem_addr); else passed++;
      total++; if (frame_start !== 1'b0) $display("FAIL async_fs: got %b expected 0", frame_start); else passed++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if (frame_start !== 1'b0) $display("FAIL rel_fs_c1: got %b expected 0", frame_start); else passed++;
      @(negedge clk);
      total++; if (frame_start !== 1'b1) $display("FAIL rel_fs_c2: got %b expected 1", frame_start); else passed++;
      total++; if (rgb !== EDGE_ONE) $display("FAIL rel_rgb00: got %h expected %h", rgb, EDGE_ONE); else passed++;
   endtask

   task automatic test_fetch();
      mode = 0;
      do_reset();
      for (int c = 1; c <= 3206; c++) begin
         @(negedge clk);
         if (c == 2) begin
            total++; if (rgb !== EDGE_ONE) $display("FAIL fetch_h0: got %h expected %h", rgb, EDGE_ONE); else passed++;
         end
         if (c == 3) begin
            total++; if (rgb !== EDGE_ONE) $display("FAIL fetch_hold: got %h expected %h", rgb, EDGE_ONE); else passed++;
         end
         if (c == 4) begin
            total++; if (rgb !== EDGE_ONE) $display("FAIL fetch_h1: got %h expected %h", rgb, EDGE_ONE); else passed++;
            total++; if (mem_addr !== 32'h0000_0001) $display("FAIL fetch_addr_h2: got %h expected %h", mem_addr, 32'h1); else passed++;
         end
         if (c == 6) begin
            total++; if (rgb !== EDGE_ZERO) $display("FAIL fetch_h2: got %h expected %h", rgb, EDGE_ZERO); else passed++;
         end
         if (c == 2 + 2 * 801) begin
            total++; if (rgb !== 24'hFFFFFF) $display("FAIL fetch_1_1: got %h expected %h", rgb, 24'hFFFFFF); else passed++;
         end
         if (c == 2 + 2 * 802) begin
            total++; if (rgb !== 24'h0) $display("FAIL fetch_2_1: got %h expected 0", rgb); else passed++;
         end
         if (c == 2 + 2 * 1602) begin
            total++; if (mem_addr !== 32'h0001_0001) $display("FAIL fetch_addr_3_2: got %h expected %h", mem_addr, 32'h0001_0001); else passed++;
         end
      end
   endtask

   task automatic test_hsync();
      int cnt;
      mode = 1;
      do_reset();
      cnt = 0;
      while (frame_start !== 1'b1 && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      total++; if (frame_start !== 1'b1) $display("FAIL hs_fs_seen: got %b expected 1", frame_start); else passed++;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (hsync === 1'b1 && cnt < 2000);
      total++; if (cnt != 1312) $display("FAIL hs_fall: got %0d clk expected 1312", cnt); else passed++;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (hsync === 1'b0 && cnt < 2000);
      total++; if (cnt != 192) $display("FAIL hs_low: got %0d clk expected 192", cnt); else passed++;
   endtask

   task automatic test_blanking();
      mode = 1;
      do_reset();
      for (int c = 1; c <= 1604; c++) begin
         @(negedge clk);
         if (c == 2 + 2 * 637) begin
            total++; if (mem_rd_en !== 1'b1) $display("FAIL bl_rd_639: got %b expected 1", mem_rd_en); else passed++;
         end
         if (c == 2 + 2 * 639) begin
            total++; if (rgb !== EDGE_ONE) $display("FAIL bl_rgb_639: got %h expected %h", rgb, EDGE_ONE); else passed++;
            total++; if (mem_rd_en !== 1'b0) $display("FAIL bl_rd_640: got %b expected 0", mem_rd_en); else passed++;
            total++; if (mem_addr !== '0) $display("FAIL bl_addr_640: got %h expected 0", mem_addr); else passed++;
         end
         if (c == 2 + 2 * 640) begin
            total++; if (rgb !== 24'h0) $display("FAIL bl_rgb_640: got %h expected 0", rgb); else passed++;
         end
         if (c == 2 + 2 * 799) begin
            total++; if (rgb !== 24'h0) $display("FAIL bl_rgb_799: got %h expected 0", rgb); else passed++;
            total++; if (mem_rd_en !== 1'b1) $display("FAIL bl_rd_wrap: got %b expected 1", mem_rd_en); else passed++;
         end
         if (c == 2 + 2 * 801) begin
            total++; if (rgb !== 24'hFFFFFF) $display("FAIL bl_rgb_1_1: got %h expected %h", rgb, 24'hFFFFFF); else passed++;
         end
      end
   endtask

   // One full frame: 420000 pixel ticks = 840000 clk; vsync low 2 lines = 3200 clk.
   task automatic test_vsync_frame();
      int fall;
      int rise;
      int next_fs;
      mode = 1;
      do_reset();
      fall = -1;
      rise = -1;
      next_fs = -1;
      for (int c = 1; c <= 840100 && next_fs < 0; c++) begin
         @(negedge clk);
         if (vsync === 1'b0 && fall < 0) fall = c;
         if (vsync === 1'b1 && fall >= 0 && rise < 0) rise = c;
         if (frame_start === 1'b1 && c > 2) next_fs = c;
         if (c == 2 + 2 * (479 * 800)) mode = 2;
         if (c == 2 + 2 * (479 * 800 + 10)) begin
            total++; if (rgb !== EDGE_ZERO) $display("FAIL vf_rgb_10_479: got %h expected %h", rgb, EDGE_ZERO); else passed++;
         end
         if (c == 2 + 2 * (479 * 800 + 20)) mode = 1;
         if (c == 2 + 2 * (479 * 800 + 600)) begin
            total++; if (rgb !== 24'hFFFFFF) $display("FAIL vf_rgb_600_479: got %h expected %h", rgb, 24'hFFFFFF); else passed++;
         end
         if (c == 2 + 2 * (480 * 800)) begin
            total++; if (rgb !== 24'h0) $display("FAIL vf_rgb_0_480: got %h expected 0", rgb); else passed++;
            total++; if (mem_rd_en !== 1'b0) $display("FAIL vf_rd_1_480: got %b expected 0", mem_rd_en); else passed++;
         end
      end
      total++; if (fall != 2 + 784000) $display("FAIL vs_fall: got %0d clk expected %0d", fall, 2 + 784000); else passed++;
      total++; if (rise - fall != 3200) $display("FAIL vs_low: got %0d clk expected 3200", rise - fall); else passed++;
      total++; if (next_fs != 2 + 840000) $display("FAIL frame_period: got %0d clk expected %0d", next_fs, 2 + 840000); else passed++;
   endtask

   task automatic test_border();
      mode = 2;
      do_reset();
      for (int c = 1; c <= 2 + 2 * 8639; c++) begin
         @(negedge clk);
         if (c == 2) begin
            total++; if (rgb !== EDGE_ZERO) $display("FAIL bd_0_0: got %h expected %h", rgb, EDGE_ZERO); else passed++;
         end
         if (c == 2 + 2 * 801) begin
            total++; if (rgb !== 24'h0) $display("FAIL bd_1_1: got %h expected 0", rgb); else passed++;
         end
         if (c == 2 + 2 * 8638) begin
            total++; if (rgb !== 24'h0) $display("FAIL bd_638_10: got %h expected 0", rgb); else passed++;
         end
         if (c == 2 + 2 * 8639) begin
            total++; if (rgb !== EDGE_ZERO) $display("FAIL bd_639_10: got %h expected %h", rgb, EDGE_ZERO); else passed++;
            total++; if (mem_rd_en !== 1'b0) $display("FAIL bd_rd_640_10: got %b expected 0", mem_rd_en); else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_hsync();
      test_blanking();
      test_border();
      test_vsync_frame();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
